// File: rtl/irq_dispatch.sv
// Avalon-MM master that services an interrupt controller: programs the mask,
// reads status on irq, dispatches the lowest pending source to the core.
module irq_dispatch #(
  parameter logic [31:0] INIT_MASK = 32'h0000_0003,
  parameter int          NUM_IRQ   = 2,
  parameter int          HOLDOFF   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq,
  output logic        avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  input  logic [31:0] avl_readdata,
  input  logic        avl_waitrequest,
  output logic        core_irq_req,
  output logic [4:0]  core_irq_cause,
  input  logic        core_irq_ack,
  input  logic        core_mask_we,
  input  logic [31:0] core_mask_data,
  output logic        core_mask_busy
);

  localparam logic [31:0] STAT_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << NUM_IRQ) - 32'd1);

  typedef enum logic [2:0] {
    RST, INIT_WR, IDLE, STAT_RD, DISPATCH, HOLD, MASK_WR
  } state_t;

  state_t      state_q, state_d;
  logic        rd_q, rd_d, wr_q, wr_d, addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, pend_q, pend_d;
  logic        req_q, req_d, busy_q, busy_d;
  logic [4:0]  cause_q, cause_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] stat_w;
  logic [4:0]  lowest;

  assign stat_w = avl_readdata & STAT_MASK;

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    lowest = '0;
    for (int i = 31; i >= 0; i--) begin
      if (stat_w[i]) lowest = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    req_d   = req_q;
    cause_d = cause_q;
    busy_d  = busy_q;
    hold_d  = hold_q;

    if (core_mask_we && !busy_q) begin
      pend_d = core_mask_data;
      busy_d = 1'b1;
    end

    case (state_q)
      RST: begin
        state_d = INIT_WR;
        wr_d    = 1'b1;
        addr_d  = 1'b1;
        wdata_d = INIT_MASK;
      end
      INIT_WR: begin
        if (!avl_waitrequest) begin
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        // A write requested this very cycle goes straight out with its own data.
        if (busy_q || core_mask_we) begin
          state_d = MASK_WR;
          wr_d    = 1'b1;
          addr_d  = 1'b1;
          wdata_d = busy_q ? pend_q : core_mask_data;
        end else if (irq) begin
          state_d = STAT_RD;
          rd_d    = 1'b1;
          addr_d  = 1'b0;
        end
      end
      STAT_RD: begin
        if (!avl_waitrequest) begin
          rd_d = 1'b0;
          if (stat_w != 32'd0) begin
            req_d   = 1'b1;
            cause_d = lowest;
            state_d = DISPATCH;
          end else begin
            hold_d  = 8'(HOLDOFF);
            state_d = HOLD;
          end
        end
      end
      DISPATCH: begin
        if (core_irq_ack) begin
          req_d   = 1'b0;
          hold_d  = 8'(HOLDOFF);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q <= 8'd1) state_d = IDLE;
        else                hold_d  = hold_q - 8'd1;
      end
      MASK_WR: begin
        if (!avl_waitrequest) begin
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 1'b0;
      wdata_q <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      cause_q <= '0;
      busy_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign avl_read       = rd_q;
  assign avl_write      = wr_q;
  assign avl_address    = addr_q;
  assign avl_writedata  = wdata_q;
  assign core_irq_req   = req_q;
  assign core_irq_cause = cause_q;
  assign core_mask_busy = busy_q;

endmodule
